// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 receive-side decrypt path.
package rc4_pkg;

  typedef enum logic [1:0] {
    WAIT_INIT = 2'd0,
    DROP      = 2'd1,
    RUN       = 2'd2
  } state_e;

  typedef logic [7:0] byte_t;

  localparam int RC4_DROP_N_DEF = 256;

endpackage

// File: rtl/rc4_ks_fifo.sv
// Small synchronous keystream FIFO; head is a combinational read of the oldest entry.
module rc4_ks_fifo
  import rc4_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  flush_i,
  input  logic  push_i,
  input  logic  pop_i,
  input  byte_t data_i,
  output byte_t head_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int AW = $clog2(DEPTH);

  byte_t       mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/rc4_decrypt.sv
// RC4 stream decryptor: XORs ciphertext with buffered keystream one byte for one byte.
// Define RC4_DROP_EN to discard the first DROP_N keystream bytes after each init (RC4-drop[N]).
module rc4_decrypt
  import rc4_pkg::*;
#(
  parameter int  FIFO_DEPTH = 4,
  parameter int  CNT_W      = 16,
  parameter int  DROP_N     = RC4_DROP_N_DEF,
  localparam int DROP_W     = $clog2(DROP_N + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic [7:0]        ks_data,
  input  logic              ks_valid,
  output logic              ks_ready,
  input  logic [7:0]        data_in,
  input  logic              valid,
  output logic              in_ready,
  output logic [7:0]        data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  byte_count,
  output state_e            dbg_state_o,
  output logic [DROP_W-1:0] dbg_drop_cnt_o
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high.
  // Sources hold data stable while valid is high and ready is low; ready never depends on
  // the same-cycle valid of its own channel.

  state_e             state_q, state_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
  byte_t              data_out_q, data_out_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   byte_count_q, byte_count_d;
  logic               fifo_full, fifo_empty, fifo_push;
  logic               ks_push, accept, flush;
  byte_t              fifo_head;

`ifdef RC4_DROP_EN
  localparam logic [DROP_W-1:0] DROP_LAST = DROP_W'(DROP_N - 1);
`endif

  assign flush    = ~init_done;
  assign ks_ready = (state_q != WAIT_INIT) & init_done & ~fifo_full;
  assign ks_push  = ks_valid & ks_ready;
  assign in_ready = (state_q == RUN) & ~fifo_empty & (~out_valid_q | out_ready);
  assign accept   = valid & in_ready;

  always_comb begin
    state_d    = state_q;
    drop_cnt_d = drop_cnt_q;
    fifo_push  = 1'b0;
    unique case (state_q)
      WAIT_INIT: begin
        if (init_done) begin
`ifdef RC4_DROP_EN
          state_d = DROP;
`else
          state_d = RUN;
`endif
        end
      end
      DROP: begin
`ifdef RC4_DROP_EN
        // Dropped bytes bypass the FIFO entirely; only the count advances.
        if (ks_push) begin
          drop_cnt_d = drop_cnt_q + 1'b1;
          if (drop_cnt_q == DROP_LAST) state_d = RUN;
        end
`else
        state_d = RUN;
`endif
      end
      RUN:     fifo_push = ks_push;
      default: state_d = WAIT_INIT;
    endcase
    if (!init_done) begin
      state_d    = WAIT_INIT;
      drop_cnt_d = '0;
    end
  end

  always_comb begin
    data_out_d   = data_out_q;
    out_valid_d  = out_valid_q;
    byte_count_d = byte_count_q;
    if (accept) begin
      data_out_d   = data_in ^ fifo_head;
      out_valid_d  = 1'b1;
      byte_count_d = byte_count_q + 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    // Re-key clears the count but a pending output byte survives until consumed.
    if (!init_done) byte_count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_INIT;
      drop_cnt_q   <= '0;
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      drop_cnt_q   <= drop_cnt_d;
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      byte_count_q <= byte_count_d;
    end
  end

  rc4_ks_fifo #(.DEPTH(FIFO_DEPTH)) u_ks_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .push_i  (fifo_push),
    .pop_i   (accept),
    .data_i  (ks_data),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign data_out       = data_out_q;
  assign out_valid      = out_valid_q;
  assign byte_count     = byte_count_q;
  assign dbg_state_o    = state_q;
  assign dbg_drop_cnt_o = drop_cnt_q;

endmodule
